// File: rtl/md_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, a, b, input busy, hi, lo);
    modport slave  (input start, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and mthi/mtlo moves.
//   state  | meaning
//   S_IDLE | ready; start accepts mult/div or performs mthi/mtlo immediately
//   S_BUSY | operation in flight; down-counter runs to terminal count 0
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [1:0]     r_op;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;

    logic           w_accept;
    logic           w_mthi;
    logic           w_mtlo;
    logic           w_done;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            w_accept = 1'b1;
                            w_next   = S_BUSY;
                        end
                        3'b100:  w_mthi = 1'b1;
                        3'b101:  w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result datapath works only from the latched operands.
    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_write;

    assign w_signed = ~r_op[0];
    assign w_is_div = r_op[1];
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_abs_a  = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b  = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_dvd    = w_signed ? w_abs_a : r_a;
    // Magnitude divide keeps 0x80000000 / -1 well defined; zero divisor is masked off.
    assign w_dvs    = (r_b == 32'd0) ? 32'd1 : (w_signed ? w_abs_b : r_b);
    assign w_q      = w_dvd / w_dvs;
    assign w_r      = w_dvd % w_dvs;
    assign w_write  = !(w_is_div && (r_b == 32'd0));

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        if (w_is_div) begin
            if (w_signed) begin
                w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q) : w_q;
                w_res_hi = r_a[31] ? (32'd0 - w_r) : w_r;
            end else begin
                w_res_lo = w_q;
                w_res_hi = w_r;
            end
        end else begin
            w_res_hi = w_signed ? w_prod_s[63:32] : w_prod_u[63:32];
            w_res_lo = w_signed ? w_prod_s[31:0]  : w_prod_u[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 2'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_op  <= bus.md_op[1:0];
                r_cnt <= bus.md_op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_mthi) r_hi <= bus.a;
            if (w_mtlo) r_lo <= bus.a;
            if (w_done && w_write) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign bus.busy = (r_state == S_BUSY);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: vector table plus multi-cycle corner sequences.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    md_unit_if md();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (md)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns busy-cycle count and whether hi/lo held while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit hold_ok);
        logic [31:0] hi0, lo0;
        hi0 = md.hi;
        lo0 = md.lo;
        md.start = 1'b1;
        md.md_op = op;
        md.a = a;
        md.b = b;
        @(posedge clk); #1;
        md.start = 1'b0;
        md.a = 32'hA5A5_5A5A;
        md.b = 32'h0000_0003;
        cyc = 0;
        hold_ok = 1'b1;
        while (md.busy && cyc < 100) begin
            if (md.hi !== hi0 || md.lo !== lo0) hold_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        bit hold_ok;
        logic [31:0] lo_before;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'b011, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFE, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[6]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7]  = '{3'b100, 32'h0000_0011, 32'h0000_0000, 0,  32'h0000_0011, 32'hFFFF_FFFD};
        vecs[8]  = '{3'b101, 32'h0000_0022, 32'h0000_0000, 0,  32'h0000_0011, 32'h0000_0022};
        vecs[9]  = '{3'b011, 32'h0000_0007, 32'h0000_0000, 10, 32'h0000_0011, 32'h0000_0022};
        vecs[10] = '{3'b001, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{3'b110, 32'h0000_0005, 32'h0000_0009, 0,  32'h0000_0001, 32'h0000_0000};

        md.start = 1'b0;
        md.md_op = 3'b000;
        md.a = 32'd0;
        md.b = 32'd0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, md.busy}, 32'd0);
        chk("reset_hi", md.hi, 32'd0);
        chk("reset_lo", md.lo, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Each vector issues in the cycle busy drops from the previous one.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, hold_ok);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cycles);
            chk($sformatf("vec%0d_hi", i), md.hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), md.lo, vecs[i].lo);
            if (vecs[i].cycles > 0) chk($sformatf("vec%0d_hold", i), {31'd0, hold_ok}, 32'd1);
        end

        // mtlo and mult presented during a div must be ignored.
        lo_before = md.lo;
        md.start = 1'b1;
        md.md_op = 3'b010;
        md.a = 32'd100;
        md.b = 32'd7;
        @(posedge clk); #1;
        md.start = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        cyc++;
        md.start = 1'b1;
        md.md_op = 3'b101;
        md.a = 32'h0000_DEAD;
        @(posedge clk); #1;
        cyc++;
        chk("mtlo_during_div_lo", md.lo, lo_before);
        md.md_op = 3'b000;
        md.a = 32'd3;
        md.b = 32'd4;
        @(posedge clk); #1;
        cyc++;
        md.start = 1'b0;
        while (md.busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("div_ignore_cycles", cyc, 10);
        chk("div_ignore_hi", md.hi, 32'd2);
        chk("div_ignore_lo", md.lo, 32'd14);
        chk("div_ignore_idle", {31'd0, md.busy}, 32'd0);

        // Reset in busy cycle 4 of a divu discards the result.
        md.start = 1'b1;
        md.md_op = 3'b011;
        md.a = 32'd9;
        md.b = 32'd2;
        @(posedge clk); #1;
        md.start = 1'b0;
        chk("rst_mid_busy1", {31'd0, md.busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_busy4", {31'd0, md.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, md.busy}, 32'd0);
        chk("rst_mid_hi", md.hi, 32'd0);
        chk("rst_mid_lo", md.lo, 32'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("rst_late_busy", {31'd0, md.busy}, 32'd0);
        chk("rst_late_hi", md.hi, 32'd0);
        chk("rst_late_lo", md.lo, 32'd0);

        // Reset wins over a same-cycle start.
        reset = 1'b1;
        md.start = 1'b1;
        md.md_op = 3'b100;
        md.a = 32'h0000_0055;
        @(posedge clk); #1;
        reset = 1'b0;
        md.start = 1'b0;
        chk("rst_prio_hi", md.hi, 32'd0);

        run_op(3'b100, 32'h0000_1234, 32'd0, cyc, hold_ok);
        chk("mthi_hi", md.hi, 32'h0000_1234);
        chk("mthi_busy", {31'd0, md.busy}, 32'd0);
        chk("mthi_lo", md.lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
